soc_pll_rst_seq: RTL and testbench
==================================

// Module: soc_pll_rst_seq
// PURPOSE
//  PLL supervisor and reset sequencer. Runs on the 50 MHz reference clock and drives the SoC PLL RESET input.
//  Qualifies PLL LOCK, then releases per-domain reset requests in fixed order: bus, core, ddr, rtc.
//  Re-runs the sequence on loss of lock or a software request; parks in FAIL after repeated lock timeouts.
//  Per-domain 2-FF reset synchronisers sit downstream in each clock domain and are not part of this block.
// PARAMETERS
//  N_DOM            4        number of reset domains; index 0 is released first
//  PLL_RST_CYC      100      o_pll_rst high time per attempt, cycles (2 us)
//  LOCK_FILT_CYC    1024     consecutive synced-lock cycles required before release
//  LOCK_TIMEOUT_CYC 500000   max cycles from PLL reset release to qualified lock (10 ms)
//  REL_STAGGER_CYC  16       cycles between successive domain releases; must be >= 1
//  MAX_RETRY        3        timeouts retried before FAIL
// PORTS
//  i_clk          in   1      50 MHz reference clock
//  i_rst_n        in   1      async assert, active-low; release synchronised upstream
//  i_pll_lock     in   1      PLL LOCK, asynchronous; 2-FF synchronised internally
//  i_sw_rst       in   1      software re-sequence request, async level; rising edge acts
//  o_pll_rst      out  1      to PLL RESET, active-high
//  o_dom_rst_n    out  N_DOM  per-domain reset request, active-low
//  o_ready        out  1      all domains released, state RUN
//  o_fail         out  1      retries exhausted, state FAIL
//  o_retry_cnt    out  2      timeouts in current bring-up; saturates at MAX_RETRY
//  o_loss_cnt     out  8      lock-loss events since i_rst_n; saturates at 255
// BEHAVIOUR
//  Reset values (asynchronous on i_rst_n low):
//   state=PLL_RST, o_pll_rst=1, o_dom_rst_n='0, o_ready=0, o_fail=0, counters=0.
//  All outputs are registered. lock_s and sw_s are the 2-FF synchronised copies. sw_re = sw_s & ~sw_s_d.
//  Counters: phase cnt and tmo cnt, each $clog2(max+1) wide, unsigned. tmo cnt clears only on entry to PLL_RST.
//  PLL_RST:
//   - o_pll_rst=1; stay PLL_RST_CYC cycles.
//   - Then o_pll_rst<=0 and go to WAIT_LOCK.
//  WAIT_LOCK:
//   - lock_s -> FILTER, phase cnt=0.
//   - Else if tmo cnt reaches LOCK_TIMEOUT_CYC-1: go to FAIL when retry==MAX_RETRY; otherwise retry++ and go to PLL_RST.
//  FILTER:
//   - ~lock_s -> WAIT_LOCK. The filter restarts on the next lock, and tmo cnt keeps running.
//   - Phase cnt reaches LOCK_FILT_CYC-1 -> RELEASE, and o_dom_rst_n[0]<=1.
//  RELEASE:
//   - Bit i deasserts i*REL_STAGGER_CYC cycles after bit 0.
//   - One cycle after the last bit: go to RUN, o_ready<=1, retry<=0.
//  RUN: hold until a lock loss or sw_re.
//  Lock loss (~lock_s in RELEASE or RUN):
//   - Next edge: o_dom_rst_n<='0, o_ready<=0, o_loss_cnt++, go to PLL_RST, retry kept.
//   - Latency from i_pll_lock fall to o_dom_rst_n low is 3 cycles.
//  FAIL:
//   - o_fail=1, o_pll_rst=1, o_dom_rst_n='0.
//   - Exit only via i_rst_n or sw_re.
//  sw_re:
//   - Any state except PLL_RST -> PLL_RST next edge, o_dom_rst_n<='0, o_ready<=0, o_fail<=0, retry<=0.
//   - o_loss_cnt is not incremented.
//  Simultaneous events:
//   - sw_re wins over lock loss and over timeout.
//   - Lock loss wins over a stagger step in RELEASE.
//  Reset mid-operation (any state): immediate async return to reset values, no clock required.
// STRUCTURE
//  Package soc_rst_pkg:
//   - typedef enum logic [2:0] rst_state_e {PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN, FAIL}
//   - Domain index constants DOM_BUS=0, DOM_CORE=1, DOM_DDR=2, DOM_RTC=3.
//  Sub-module soc_sync2: generic 2-FF synchroniser with async active-low reset and a reset-value parameter.
//   - Used for i_pll_lock and i_sw_rst.
//  One FSM always_ff block plus counter logic.
// TESTING
//  Bench parameters: PLL_RST_CYC=4, LOCK_FILT_CYC=8, LOCK_TIMEOUT_CYC=32, REL_STAGGER_CYC=2, MAX_RETRY=2.
//  1. Clean bring-up: lock rises 5 cycles after o_pll_rst falls.
//     -> o_pll_rst high exactly 4 cycles.
//     -> bit0 releases 2+8 cycles after lock rise; bits 1,2,3 at +2,+4,+6.
//     -> o_ready=1 one cycle after bit3; o_retry_cnt=0.
//  2. Lock glitch: lock high 5 cycles, low 1, high.
//     -> no release until 8 consecutive synced-high cycles; o_dom_rst_n stays 4'b0000 meanwhile.
//  3. Lock never asserts.
//     -> o_pll_rst pulses 3 times, each 4 cycles, 32-cycle gaps.
//     -> then o_fail=1, o_pll_rst=1, o_retry_cnt=2.
//  4. Lock drop in RUN.
//     -> o_dom_rst_n=4'b0000 and o_ready=0 exactly 3 cycles after the drop; o_loss_cnt=1.
//     -> full re-sequence completes when lock returns.
//  5. sw_rst rising edge in FAIL, lock held high.
//     -> o_fail=0, o_retry_cnt=0, o_pll_rst 4 cycles, normal release; o_loss_cnt unchanged.
//  6. i_rst_n low mid-RELEASE with o_dom_rst_n=4'b0011, clock stopped.
//     -> all outputs at reset values immediately.

Source files
------------

// File: rtl/soc_rst_pkg.sv
// ----------------------------------------------------------------------------
// soc_rst_pkg : shared types and constants for the PLL supervisor / reset sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package soc_rst_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } rst_state_e;

   // Release order: lower index leaves reset first.
   localparam int DOM_BUS  = 0;
   localparam int DOM_CORE = 1;
   localparam int DOM_DDR  = 2;
   localparam int DOM_RTC  = 3;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/soc_sync2.sv
// ----------------------------------------------------------------------------
// soc_sync2 : two-flop synchroniser, async active-low reset to RST_VAL
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module soc_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/soc_pll_rst_seq.sv
// ----------------------------------------------------------------------------
// soc_pll_rst_seq : PLL lock supervisor and ordered per-domain reset release
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module soc_pll_rst_seq
   import soc_rst_pkg::*;
#(
   parameter int unsigned N_DOM            = 4,
   parameter int unsigned PLL_RST_CYC      = 100,
   parameter int unsigned LOCK_FILT_CYC    = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
   parameter int unsigned REL_STAGGER_CYC  = 16,
   parameter int unsigned MAX_RETRY        = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pll_lock,
   input  logic             i_sw_rst,
   output logic             o_pll_rst,
   output logic [N_DOM-1:0] o_dom_rst_n,
   output logic             o_ready,
   output logic             o_fail,
   output logic [1:0]       o_retry_cnt,
   output logic [7:0]       o_loss_cnt
);

   localparam int unsigned c_rel_cyc = (N_DOM - 1) * REL_STAGGER_CYC + 1;
   localparam int unsigned c_ph_max  = max3(PLL_RST_CYC, LOCK_FILT_CYC, c_rel_cyc);
   localparam int unsigned PH_W      = $clog2(c_ph_max + 1);
   localparam int unsigned TMO_W     = $clog2(LOCK_TIMEOUT_CYC + 1);

   localparam logic [PH_W-1:0]  c_pll_last  = PH_W'(PLL_RST_CYC - 1);
   localparam logic [PH_W-1:0]  c_filt_last = PH_W'(LOCK_FILT_CYC - 1);
   localparam logic [PH_W-1:0]  c_rel_last  = PH_W'(c_rel_cyc);
   localparam logic [TMO_W-1:0] c_tmo_last  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [1:0]       c_max_retry = 2'(MAX_RETRY);

   rst_state_e        r_state;
   logic [PH_W-1:0]   r_phase;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_pll_rst;
   logic [N_DOM-1:0]  r_dom_rst_n;
   logic              r_ready;
   logic              r_fail;
   logic [1:0]        r_retry;
   logic [7:0]        r_loss;
   logic              r_sw_d;

   logic              w_lock_s;
   logic              w_sw_s;
   logic              w_sw_re;
   logic              w_lock_lost;
   logic [PH_W-1:0]   w_phase_inc;
   logic [TMO_W-1:0]  w_tmo_inc;
   logic [N_DOM-1:0]  w_rel_mask;

   soc_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_pll_lock),
      .o_q     (w_lock_s)
   );

   // Reset value 1 so a request held through reset does not fire on release.
   soc_sync2 #(.RST_VAL(1'b1)) u_sw_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_sw_rst),
      .o_q     (w_sw_s)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sw_d <= 1'b1;
      else          r_sw_d <= w_sw_s;
   end

   assign w_sw_re     = w_sw_s & ~r_sw_d;
   assign w_lock_lost = ~w_lock_s & ((r_state == RELEASE) || (r_state == RUN));
   assign w_phase_inc = r_phase + PH_W'(1);
   assign w_tmo_inc   = (r_tmo == c_tmo_last) ? r_tmo : r_tmo + TMO_W'(1);

   generate
      for (genvar gi = 0; gi < N_DOM; gi++) begin : g_rel
         if (gi == 0) begin : g_first
            assign w_rel_mask[gi] = 1'b1;
         end else begin : g_rest
            assign w_rel_mask[gi] = (w_phase_inc >= PH_W'(gi * REL_STAGGER_CYC));
         end
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= PLL_RST;
         r_phase     <= '0;
         r_tmo       <= '0;
         r_pll_rst   <= 1'b1;
         r_dom_rst_n <= '0;
         r_ready     <= 1'b0;
         r_fail      <= 1'b0;
         r_retry     <= '0;
         r_loss      <= '0;
      end else if (w_sw_re && (r_state != PLL_RST)) begin
         r_state     <= PLL_RST;
         r_phase     <= '0;
         r_tmo       <= '0;
         r_pll_rst   <= 1'b1;
         r_dom_rst_n <= '0;
         r_ready     <= 1'b0;
         r_fail      <= 1'b0;
         r_retry     <= '0;
      end else if (w_lock_lost) begin
         r_state     <= PLL_RST;
         r_phase     <= '0;
         r_tmo       <= '0;
         r_pll_rst   <= 1'b1;
         r_dom_rst_n <= '0;
         r_ready     <= 1'b0;
         if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
      end else begin
         case (r_state)
            PLL_RST: begin
               if (r_phase == c_pll_last) begin
                  r_pll_rst <= 1'b0;
                  r_phase   <= '0;
                  r_state   <= WAIT_LOCK;
               end else begin
                  r_phase <= w_phase_inc;
               end
            end
            WAIT_LOCK: begin
               if (w_lock_s) begin
                  r_phase <= '0;
                  r_tmo   <= w_tmo_inc;
                  r_state <= FILTER;
               end else if (r_tmo == c_tmo_last) begin
                  r_pll_rst <= 1'b1;
                  if (r_retry == c_max_retry) begin
                     r_fail  <= 1'b1;
                     r_state <= FAIL;
                  end else begin
                     r_retry <= r_retry + 2'd1;
                     r_phase <= '0;
                     r_tmo   <= '0;
                     r_state <= PLL_RST;
                  end
               end else begin
                  r_tmo <= w_tmo_inc;
               end
            end
            FILTER: begin
               r_tmo <= w_tmo_inc;
               if (!w_lock_s) begin
                  r_state <= WAIT_LOCK;
               end else if (w_phase_inc == c_filt_last) begin
                  // The WAIT_LOCK cycle that saw lock counts as the first qualified sample.
                  r_dom_rst_n          <= '0;
                  r_dom_rst_n[DOM_BUS] <= 1'b1;
                  r_phase              <= '0;
                  r_state              <= RELEASE;
               end else begin
                  r_phase <= w_phase_inc;
               end
            end
            RELEASE: begin
               if (w_phase_inc == c_rel_last) begin
                  r_ready <= 1'b1;
                  r_retry <= '0;
                  r_state <= RUN;
               end else begin
                  r_phase     <= w_phase_inc;
                  r_dom_rst_n <= w_rel_mask;
               end
            end
            RUN, FAIL: begin
            end
            default: begin
               r_state <= PLL_RST;
            end
         endcase
      end
   end

   assign o_pll_rst   = r_pll_rst;
   assign o_dom_rst_n = r_dom_rst_n;
   assign o_ready     = r_ready;
   assign o_fail      = r_fail;
   assign o_retry_cnt = r_retry;
   assign o_loss_cnt  = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_soc_pll_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_soc_pll_rst_seq : randomized scoreboard bench for soc_pll_rst_seq
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_soc_pll_rst_seq;

   localparam int P_PLL   = 4;
   localparam int P_FILT  = 8;
   localparam int P_TMO   = 32;
   localparam int P_STG   = 2;
   localparam int P_RETRY = 2;
   localparam int NPLAN   = 4096;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       lock   = 1'b0;
   logic       sw     = 1'b0;
   logic       pll_rst;
   logic [3:0] dom_rst_n;
   logic       ready;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   bit clk_en = 1'b1;
   bit mon_en = 1'b1;
   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   bit plan_lock [NPLAN];
   bit plan_sw   [NPLAN];

   typedef struct {
      int          t;
      logic [16:0] v;
   } ev_t;
   ev_t exp_q[$];

   bit       m_pll   = 1'b1;
   bit [3:0] m_dom   = 4'b0000;
   bit       m_rdy   = 1'b0;
   bit       m_fail  = 1'b0;
   int       m_retry = 0;
   int       m_loss  = 0;

   soc_pll_rst_seq #(
      .N_DOM            (4),
      .PLL_RST_CYC      (P_PLL),
      .LOCK_FILT_CYC    (P_FILT),
      .LOCK_TIMEOUT_CYC (P_TMO),
      .REL_STAGGER_CYC  (P_STG),
      .MAX_RETRY        (P_RETRY)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_pll_lock  (lock),
      .i_sw_rst    (sw),
      .o_pll_rst   (pll_rst),
      .o_dom_rst_n (dom_rst_n),
      .o_ready     (ready),
      .o_fail      (fail),
      .o_retry_cnt (retry_cnt),
      .o_loss_cnt  (loss_cnt)
   );

   always #5 if (clk_en) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [16:0] pack(input bit pll, input bit [3:0] dom, input bit rdy,
                                        input bit fl, input int rt, input int ls);
      return {pll, dom, rdy, fl, 2'(rt), 8'(ls)};
   endfunction

   function automatic logic [16:0] dut_bundle();
      return {pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt};
   endfunction

   task automatic push(input int t);
      ev_t e;
      e.t = t;
      e.v = pack(m_pll, m_dom, m_rdy, m_fail, m_retry, m_loss);
      exp_q.push_back(e);
   endtask

   task automatic set_lock(input int from, input bit v);
      for (int i = from; i < NPLAN; i++) plan_lock[i] = v;
   endtask

   // Lock driven in cycle c is first acted on by the sequencer at cycle c+3.
   function automatic bit vis(input int t);
      return (t >= 3) ? plan_lock[t-3] : 1'b0;
   endfunction

   // Release happens at the end of the first run of 8 visible-high samples after PLL reset drops.
   function automatic int find_release(input int w);
      for (int t = w + 1; t < w + 200; t++) begin
         bit ok;
         ok = 1'b1;
         for (int k = 0; k < P_FILT; k++) if (!vis(t + k)) ok = 1'b0;
         if (ok) return t + P_FILT - 1;
      end
      return -1;
   endfunction

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Bring-up from PLL_RST entry at cycle p. drop>0 loses lock at release+drop; events after release+cut are not expected.
   task automatic bringup(input int p, input int d, input int h, input int g,
                          input int drop, input int cut, output int r);
      int w;
      int t;
      w = p + P_PLL;
      m_pll = 1'b0;
      push(w);
      if (h > 0) begin
         set_lock(w + d, 1'b1);
         set_lock(w + d + h, 1'b0);
         set_lock(w + d + h + g, 1'b1);
      end else begin
         set_lock(w + d, 1'b1);
      end
      r = find_release(w);
      for (int i = 0; i <= 4; i++) begin
         t = (i < 4) ? r + i * P_STG : r + 3 * P_STG + 1;
         if ((drop > 0 && t >= r + drop) || t > r + cut) break;
         if (i < 4) m_dom[i] = 1'b1;
         else begin
            m_rdy   = 1'b1;
            m_retry = 0;
         end
         push(t);
      end
      if (drop > 0) begin
         set_lock(r + drop - 3, 1'b0);
         m_dom  = 4'b0000;
         m_rdy  = 1'b0;
         m_pll  = 1'b1;
         m_loss = (m_loss < 255) ? m_loss + 1 : 255;
         push(r + drop);
      end
   endtask

   task automatic nolock(input int p, output int tf);
      int w;
      w = p + P_PLL;
      forever begin
         m_pll = 1'b0;
         push(w);
         m_pll = 1'b1;
         if (m_retry == P_RETRY) begin
            m_fail = 1'b1;
            push(w + P_TMO);
            tf = w + P_TMO;
            break;
         end
         m_retry++;
         push(w + P_TMO);
         w = w + P_TMO + P_PLL;
      end
   endtask

   task automatic sw_pulse(input int c);
      for (int i = c; i < c + 6; i++) plan_sw[i] = 1'b1;
      m_dom   = 4'b0000;
      m_rdy   = 1'b0;
      m_fail  = 1'b0;
      m_retry = 0;
      m_pll   = 1'b1;
      push(c + 3);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cyc < NPLAN) begin
            lock = plan_lock[cyc];
            sw   = plan_sw[cyc];
         end
      end
   end

   initial begin
      logic [16:0] prev;
      logic [16:0] cur;
      ev_t         e;
      prev = pack(1'b1, 4'b0000, 1'b0, 1'b0, 0, 0);
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = dut_bundle();
            if (cur !== prev) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_change: cyc %0d got %h, nothing expected", cyc, cur);
               end else begin
                  e = exp_q.pop_front();
                  if (e.t != cyc || e.v !== cur) begin
                     errors++;
                     $display("FAIL out_event: cyc %0d got %h, expected cyc %0d value %h",
                              cyc, cur, e.t, e.v);
                  end
               end
               prev = cur;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int r;
      int tf;
      int c;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_bundle", 32'(dut_bundle()), 32'(pack(1'b1, 4'b0000, 1'b0, 1'b0, 0, 0)));
      while (cyc < 2) @(negedge clk);
      rst_n = 1'b1;
      p = cyc;

      bringup(p, 5, 0, 0, 10, 99, r);
      p = r + 10;

      for (int it = 0; it < 8; it++) begin
         int d;
         int h;
         int g;
         d = $urandom_range(0, 6);
         h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
         g = $urandom_range(1, 3);
         c = $urandom_range(1, 20);
         bringup(p, d, h, g, c, 99, r);
         p = r + c;
         wait_until(p);
      end

      nolock(p, tf);
      wait_until(tf + 3);

      c = cyc + 2;
      set_lock(c, 1'b1);
      sw_pulse(c);
      bringup(c + 3, 0, 0, 0, 0, 99, r);
      wait_until(r + 10);

      c = cyc + 2 + $urandom_range(0, 5);
      sw_pulse(c);
      bringup(c + 3, 0, 0, 0, 0, P_STG, r);
      wait_until(r + P_STG + 1);
      #1;
      chk("pending_events", 32'(exp_q.size()), 32'd0);

      clk_en = 1'b0;
      mon_en = 1'b0;
      chk("dom_mid_release", 32'(dom_rst_n), 32'h3);
      #3 rst_n = 1'b0;
      #1;
      chk("async_pll_rst", 32'(pll_rst), 32'd1);
      chk("async_dom_rst_n", 32'(dom_rst_n), 32'd0);
      chk("async_ready", 32'(ready), 32'd0);
      chk("async_fail", 32'(fail), 32'd0);
      chk("async_retry", 32'(retry_cnt), 32'd0);
      chk("async_loss", 32'(loss_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
